// File: rtl/kbd_pkg.sv
// Shared definitions for the keyboard number path: PS/2 scan codes, prefix
// FSM encoding and the digit decoder.
package kbd_pkg;

    localparam logic [7:0] SC_D0    = 8'h45;
    localparam logic [7:0] SC_D1    = 8'h16;
    localparam logic [7:0] SC_D2    = 8'h1E;
    localparam logic [7:0] SC_D3    = 8'h26;
    localparam logic [7:0] SC_D4    = 8'h25;
    localparam logic [7:0] SC_D5    = 8'h2E;
    localparam logic [7:0] SC_D6    = 8'h36;
    localparam logic [7:0] SC_D7    = 8'h3D;
    localparam logic [7:0] SC_D8    = 8'h3E;
    localparam logic [7:0] SC_D9    = 8'h46;
    localparam logic [7:0] SC_ENTER = 8'h5A;
    localparam logic [7:0] SC_BKSP  = 8'h66;
    localparam logic [7:0] SC_ESC   = 8'h76;
    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BRK     = 2'd1,
        ST_EXT     = 2'd2,
        ST_EXT_BRK = 2'd3
    } prefix_state_e;

    // Returns {valid, value}; valid is low for anything that is not a digit key.
    function automatic logic [4:0] decode_digit(input logic [7:0] sc);
        case (sc)
            SC_D0:   return {1'b1, 4'd0};
            SC_D1:   return {1'b1, 4'd1};
            SC_D2:   return {1'b1, 4'd2};
            SC_D3:   return {1'b1, 4'd3};
            SC_D4:   return {1'b1, 4'd4};
            SC_D5:   return {1'b1, 4'd5};
            SC_D6:   return {1'b1, 4'd6};
            SC_D7:   return {1'b1, 4'd7};
            SC_D8:   return {1'b1, 4'd8};
            SC_D9:   return {1'b1, 4'd9};
            default: return {1'b0, 4'd0};
        endcase
    endfunction

    function automatic longint unsigned pow10(input int n);
        longint unsigned r;
        r = 64'd1;
        for (int i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

endpackage

// File: rtl/kbd_num_fifo_sync_fifo.sv
// Synchronous FIFO with registered head/count/flags; a push and a pop in the
// same cycle are both honoured, including when the FIFO is full.
module sync_fifo #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic [DATA_WIDTH-1:0]        din,
    input  logic                         pop,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic [DATA_WIDTH-1:0]        head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic                  push_ok;
    logic                  pop_ok;

    // Next-state for pointers, occupancy and the registered head value.
    always_comb begin
        pop_ok  = pop && !empty_q;
        push_ok = push && (!full_q || pop_ok);

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        full_d  = (count_d == CNT_W'(DEPTH));
        empty_d = (count_d == CNT_W'(0));

        // The slot being written becomes the head only when nothing older remains.
        if (empty_d) begin
            head_d = {DATA_WIDTH{1'b0}};
        end else if (push_ok && (rd_ptr_d == wr_ptr_q)) begin
            head_d = din;
        end else begin
            head_d = mem_q[rd_ptr_d];
        end
    end

    // Control and status registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
            head_q   <= {DATA_WIDTH{1'b0}};
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage array.
    always_ff @(posedge clk) begin
        if (rst_n && push_ok) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign full  = full_q;
    assign empty = empty_q;
    assign count = count_q;
    assign head  = head_q;

endmodule

// File: rtl/kbd_num_fifo.sv
// Assembles multi-digit decimal numbers from PS/2 make codes (with Backspace
// and Escape editing) and queues completed numbers for the CPU.
module kbd_num_fifo
    import kbd_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int DIGITS     = 4,
    parameter int DEPTH      = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         code_valid,
    input  logic [7:0]                   code,
    input  logic                         control,
    output logic                         status,
    output logic [DATA_WIDTH-1:0]        num,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic [DATA_WIDTH-1:0]        entry,
    output logic                         overflow
);

    localparam int DIG_W = $clog2(DIGITS+1);

    if (pow10(DIGITS) - 64'd1 >= (64'd1 << DATA_WIDTH)) begin : g_bad_digits
        $error("kbd_num_fifo: DIGITS decimal digits do not fit in DATA_WIDTH bits");
    end
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("kbd_num_fifo: DEPTH must be a power of two and at least 2");
    end

    prefix_state_e         state_q, state_d;
    logic [DATA_WIDTH-1:0] entry_q, entry_d;
    logic [DIG_W-1:0]      ndig_q, ndig_d;
    logic                  overflow_q, overflow_d;
    logic                  commit_req;
    logic                  push;
    logic                  pop;
    logic [4:0]            dig;
    logic                  fifo_full;
    logic                  fifo_empty;

    // Prefix FSM, entry editing and commit decision.
    always_comb begin
        state_d    = state_q;
        entry_d    = entry_q;
        ndig_d     = ndig_q;
        overflow_d = overflow_q;
        commit_req = 1'b0;
        dig        = decode_digit(code);

        if (code_valid) begin
            case (state_q)
                ST_IDLE: begin
                    if (code == SC_BRK) begin
                        state_d = ST_BRK;
                    end else if (code == SC_EXT) begin
                        state_d = ST_EXT;
                    end else if (dig[4]) begin
                        if (ndig_q < DIG_W'(DIGITS)) begin
                            entry_d = entry_q * DATA_WIDTH'(10) + DATA_WIDTH'(dig[3:0]);
                            ndig_d  = ndig_q + DIG_W'(1);
                        end else begin
                            entry_d = entry_q;
                        end
                    end else if (code == SC_ENTER) begin
                        commit_req = 1'b1;
                    end else if (code == SC_BKSP) begin
                        if (ndig_q != DIG_W'(0)) begin
                            entry_d = entry_q / DATA_WIDTH'(10);
                            ndig_d  = ndig_q - DIG_W'(1);
                        end else begin
                            entry_d = entry_q;
                        end
                    end else if (code == SC_ESC) begin
                        entry_d = {DATA_WIDTH{1'b0}};
                        ndig_d  = {DIG_W{1'b0}};
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_BRK: state_d = ST_IDLE;
                ST_EXT: begin
                    if (code == SC_BRK) begin
                        state_d = ST_EXT_BRK;
                    end else if (code == SC_ENTER) begin
                        commit_req = 1'b1;
                        state_d    = ST_IDLE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_EXT_BRK: state_d = ST_IDLE;
                default:    state_d = ST_IDLE;
            endcase
        end else begin
            state_d = state_q;
        end

        pop  = control && !fifo_empty;
        push = commit_req && (ndig_q != DIG_W'(0));

        // A full FIFO still frees a slot if the CPU reads in the same cycle.
        if (push) begin
            entry_d = {DATA_WIDTH{1'b0}};
            ndig_d  = {DIG_W{1'b0}};
            if (fifo_full && !pop) begin
                overflow_d = 1'b1;
            end else begin
                overflow_d = overflow_q;
            end
        end else begin
            overflow_d = overflow_q;
        end
    end

    // Accumulator and FSM registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            entry_q    <= {DATA_WIDTH{1'b0}};
            ndig_q     <= {DIG_W{1'b0}};
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            entry_q    <= entry_d;
            ndig_q     <= ndig_d;
            overflow_q <= overflow_d;
        end
    end

    sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (entry_q),
        .pop   (pop),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (count),
        .head  (num)
    );

    assign status   = !fifo_empty;
    assign entry    = entry_q;
    assign overflow = overflow_q;

endmodule
